// File: rtl/game_pkg.sv
// Shared types and constants for the inter-board shot/result link.
package game_pkg;

    localparam logic [7:0] SHOT_HDR = 8'hA5;
    localparam logic [7:0] RES_HDR  = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        S_HDR,
        S_ADDR,
        WAIT_RES,
        LOOKUP,
        R_HDR,
        R_PAY
    } link_state_t;

    typedef enum logic {
        RX_HDR,
        RX_PAY
    } rx_state_t;

    function automatic logic addr_valid(input logic [7:0] addr);
        return (addr[7:4] <= 4'd9) && (addr[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/shot_link_ctl_rx_parser.sv
// Splits the rx byte stream into SHOT (pending slot) and RESULT (pulse) messages.
module link_rx_parser
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       clr_pend,
    output logic       pend_v,
    output logic [7:0] pend_addr,
    output logic       res_v,
    output logic       res_hit
);

    rx_state_t  st_q;
    logic       is_shot_q;
    logic       pend_v_q;
    logic [7:0] pend_addr_q;
    logic       res_v_q;
    logic       res_hit_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= RX_HDR;
            is_shot_q   <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= 8'h00;
            res_v_q     <= 1'b0;
            res_hit_q   <= 1'b0;
        end else begin
            res_v_q <= 1'b0;
            if (clr_pend)
                pend_v_q <= 1'b0;
            if (rx_valid) begin
                unique case (st_q)
                    RX_HDR: begin
                        is_shot_q <= (rx_data == SHOT_HDR);
                        if (rx_data == SHOT_HDR || rx_data == RES_HDR)
                            st_q <= RX_PAY;
                    end
                    RX_PAY: begin
                        st_q <= RX_HDR;
                        // A fresh SHOT beats a same-cycle clear so it is never lost
                        if (is_shot_q) begin
                            pend_v_q    <= 1'b1;
                            pend_addr_q <= rx_data;
                        end else begin
                            res_v_q   <= 1'b1;
                            res_hit_q <= rx_data[0];
                        end
                    end
                    default: st_q <= RX_HDR;
                endcase
            end
        end
    end

    assign pend_v    = pend_v_q;
    assign pend_addr = pend_addr_q;
    assign res_v     = res_v_q;
    assign res_hit   = res_hit_q;

endmodule

// File: rtl/shot_link_ctl.sv
// Shot/result exchange sequencer between the game FSM and the UART byte link.
module shot_link_ctl
    import game_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 65_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shot_req,
    input  logic [7:0] shot_addr,
    output logic       busy,
    output logic       shot_done,
    output logic       shot_hit,
    output logic       shot_fail,
    output logic       look_req,
    output logic [7:0] look_addr,
    input  logic       look_ack,
    input  logic       look_hit,
    output logic       in_shot,
    output logic [7:0] in_addr,
    output logic       in_hit,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid
);

    link_state_t state_q;
    link_state_t ret_q;
    logic [31:0] timer_q;
    logic [3:0]  retry_q;
    logic [7:0]  addr_q;
    logic        busy_q;
    logic        done_q;
    logic        hit_q;
    logic        fail_q;
    logic        look_req_q;
    logic [7:0]  look_addr_q;
    logic        in_shot_q;
    logic [7:0]  in_addr_q;
    logic        in_hit_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;

    logic       pend_v;
    logic [7:0] pend_addr;
    logic       res_v;
    logic       res_hit;
    logic       clr_pend;
    logic       tx_fire;

    assign clr_pend = (state_q == LOOKUP) && look_ack;
    assign tx_fire  = tx_valid_q && tx_ready;

    link_rx_parser u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .clr_pend  (clr_pend),
        .pend_v    (pend_v),
        .pend_addr (pend_addr),
        .res_v     (res_v),
        .res_hit   (res_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ret_q       <= IDLE;
            timer_q     <= 32'd0;
            retry_q     <= 4'd0;
            addr_q      <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            fail_q      <= 1'b0;
            look_req_q  <= 1'b0;
            look_addr_q <= 8'h00;
            in_shot_q   <= 1'b0;
            in_addr_q   <= 8'h00;
            in_hit_q    <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            in_shot_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pend_v) begin
                        state_q     <= LOOKUP;
                        ret_q       <= IDLE;
                        look_req_q  <= 1'b1;
                        look_addr_q <= pend_addr;
                    end else if (shot_req) begin
                        if (addr_valid(shot_addr)) begin
                            state_q    <= S_HDR;
                            addr_q     <= shot_addr;
                            busy_q     <= 1'b1;
                            retry_q    <= 4'd0;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= SHOT_HDR;
                        end else begin
                            fail_q <= 1'b1;
                        end
                    end
                end
                S_HDR: begin
                    if (tx_fire) begin
                        state_q   <= S_ADDR;
                        tx_data_q <= addr_q;
                    end
                end
                S_ADDR: begin
                    if (tx_fire) begin
                        state_q    <= WAIT_RES;
                        tx_valid_q <= 1'b0;
                        timer_q    <= 32'd0;
                    end
                end
                WAIT_RES: begin
                    if (res_v) begin
                        state_q <= IDLE;
                        hit_q   <= res_hit;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (pend_v) begin
                        // Timer holds its value while the reply is serviced
                        state_q     <= LOOKUP;
                        ret_q       <= WAIT_RES;
                        look_req_q  <= 1'b1;
                        look_addr_q <= pend_addr;
                    end else if (timer_q == 32'(TIMEOUT_CYC - 1)) begin
                        if (retry_q < 4'(MAX_RETRY)) begin
                            state_q    <= S_HDR;
                            retry_q    <= retry_q + 4'd1;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= SHOT_HDR;
                        end else begin
                            state_q <= IDLE;
                            fail_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        timer_q <= timer_q + 32'd1;
                    end
                end
                LOOKUP: begin
                    if (look_ack) begin
                        state_q    <= R_HDR;
                        look_req_q <= 1'b0;
                        in_shot_q  <= 1'b1;
                        in_addr_q  <= look_addr_q;
                        in_hit_q   <= look_hit;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= RES_HDR;
                    end
                end
                R_HDR: begin
                    if (tx_fire) begin
                        state_q   <= R_PAY;
                        tx_data_q <= {7'b0, in_hit_q};
                    end
                end
                R_PAY: begin
                    if (tx_fire) begin
                        state_q    <= ret_q;
                        tx_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign shot_done = done_q;
    assign shot_hit  = hit_q;
    assign shot_fail = fail_q;
    assign look_req  = look_req_q;
    assign look_addr = look_addr_q;
    assign in_shot   = in_shot_q;
    assign in_addr   = in_addr_q;
    assign in_hit    = in_hit_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;

endmodule

// File: tb/tb_shot_link_ctl.sv
// Scoreboard bench for shot_link_ctl: tx bytes and event pulses are queued
// by the stimulus and consumed by an independent negedge monitor.
module tb_shot_link_ctl;

    localparam int T = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       shot_req = 1'b0;
    logic [7:0] shot_addr = 8'h00;
    logic       busy, shot_done, shot_hit, shot_fail;
    logic       look_req;
    logic [7:0] look_addr;
    logic       look_ack = 1'b0;
    logic       look_hit = 1'b0;
    logic       in_shot;
    logic [7:0] in_addr;
    logic       in_hit;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;

    shot_link_ctl #(.TIMEOUT_CYC(T), .MAX_RETRY(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .shot_req  (shot_req),
        .shot_addr (shot_addr),
        .busy      (busy),
        .shot_done (shot_done),
        .shot_hit  (shot_hit),
        .shot_fail (shot_fail),
        .look_req  (look_req),
        .look_addr (look_addr),
        .look_ack  (look_ack),
        .look_hit  (look_hit),
        .in_shot   (in_shot),
        .in_addr   (in_addr),
        .in_hit    (in_hit),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] exp_tx[$];
    ev_t        exp_ev[$];
    int         a5_t[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic ev_chk(input string name, input int kind, input int val);
        ev_t e;
        if (exp_ev.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got unexpected pulse val %0h want none",
                     name, val);
        end else begin
            e = exp_ev.pop_front();
            chk({name, "_kind"}, kind, e.kind);
            chk({name, "_val"}, val, e.val);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (tx_valid && tx_ready) begin
                if (tx_data == 8'hA5)
                    a5_t.push_back(cyc);
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_extra: got %0h want none", tx_data);
                end else begin
                    chk("tx_byte", tx_data, exp_tx.pop_front());
                end
            end
            if (shot_done)
                ev_chk("shot_done", 0, int'(shot_hit));
            if (shot_fail)
                ev_chk("shot_fail", 1, 0);
            if (in_shot)
                ev_chk("in_shot", 2, int'({in_hit, in_addr}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic fire(input logic [7:0] a);
        shot_addr = a;
        shot_req  = 1'b1;
        tick();
        shot_req  = 1'b0;
    endtask

    task automatic wait_idle(input int n, input string name);
        int k = 0;
        while (busy && k < n) begin
            tick();
            k++;
        end
        chk(name, busy, 0);
    endtask

    task automatic wait_look(input int n);
        int k = 0;
        while (!look_req && k < n) begin
            tick();
            k++;
        end
        chk("look_req_rise", look_req, 1);
    endtask

    task automatic ack(input logic h);
        look_hit = h;
        look_ack = 1'b1;
        tick();
        look_ack = 1'b0;
    endtask

    task automatic push_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_ev.push_back(e);
    endtask

    function automatic logic [31:0] outs();
        return {tx_valid, busy, look_req, shot_done, shot_fail, in_shot,
                shot_hit, in_hit, tx_data | look_addr | in_addr};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("reset_outs", outs(), 0);
        rst = 1'b1;
        tick();
        chk("post_reset_outs", outs(), 0);

        // Outgoing hit: A5,34 then 5A,01
        exp_tx.push_back(8'hA5);
        exp_tx.push_back(8'h34);
        push_ev(0, 1);
        fire(8'h34);
        chk("busy_rise", busy, 1);
        chk("tx_latency", tx_valid, 1);
        repeat (4) tick();
        send_rx(8'h5A);
        send_rx(8'h01);
        wait_idle(20, "t2_idle");
        chk("t2_hit_held", shot_hit, 1);

        // Invalid column nibble
        push_ev(1, 0);
        fire(8'h3A);
        chk("t3_busy", busy, 0);
        chk("t3_no_tx", tx_valid, 0);
        repeat (3) tick();
        chk("t3_busy_late", busy, 0);

        // No reply: one send plus three retries, then fail
        a5_t.delete();
        for (int i = 0; i < 4; i++) begin
            exp_tx.push_back(8'hA5);
            exp_tx.push_back(8'h55);
        end
        push_ev(1, 0);
        fire(8'h55);
        wait_idle(600, "t4_idle");
        chk("t4_sends", a5_t.size(), 4);
        for (int i = 1; i < a5_t.size(); i++)
            chk("t4_gap", a5_t[i] - a5_t[i-1], T + 2);
        chk("t4_hit_held", shot_hit, 1);
        repeat (2) tick();

        // Incoming shot while idle, miss
        push_ev(2, 9'h027);
        exp_tx.push_back(8'h5A);
        exp_tx.push_back(8'h00);
        send_rx(8'hA5);
        send_rx(8'h27);
        wait_look(5);
        chk("t5_look_addr", look_addr, 8'h27);
        repeat (3) tick();
        ack(1'b0);
        repeat (6) tick();
        chk("t5_look_drop", look_req, 0);
        chk("t5_tx_idle", tx_valid, 0);

        // Incoming shot interrupts a wait, then our result arrives
        exp_tx.push_back(8'hA5);
        exp_tx.push_back(8'h62);
        fire(8'h62);
        repeat (5) tick();
        push_ev(2, 9'h111);
        exp_tx.push_back(8'h5A);
        exp_tx.push_back(8'h01);
        send_rx(8'hA5);
        send_rx(8'h11);
        wait_look(5);
        chk("t6_look_addr", look_addr, 8'h11);
        chk("t6_busy", busy, 1);
        repeat (2) tick();
        ack(1'b1);
        repeat (6) tick();
        push_ev(0, 0);
        send_rx(8'h5A);
        send_rx(8'h00);
        wait_idle(20, "t6_idle");
        chk("t6_miss", shot_hit, 0);
        repeat (T + 20) tick();

        // Back-pressure in S_ADDR, then async reset mid-stall
        tx_ready = 1'b0;
        exp_tx.push_back(8'hA5);
        fire(8'h48);
        tick();
        chk("t7_hdr_hold", {tx_valid, tx_data}, 9'h1A5);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t7_addr_hold", {tx_valid, tx_data}, 9'h148);
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        chk("t7_async_rst", outs(), 0);
        tick();
        rst = 1'b1;
        tx_ready = 1'b1;
        repeat (3) tick();
        chk("t7_after_rst", outs(), 0);

        chk("tx_queue_empty", exp_tx.size(), 0);
        chk("ev_queue_empty", exp_ev.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
